// File: rtl/vcve2_fetch_fifo_gen.sv
// Instruction fetch FIFO: buffers fetched words and realigns them into 16/32-bit
// instructions for the IF stage, with a zero-latency bypass from the bus response.
module vcve2_fetch_fifo_gen #(
  parameter int unsigned NUM_REQS   = 2,
  parameter bit          RV32C      = 1'b1,
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 clear_i,
  output logic [NUM_REQS-1:0]                  busy_o,
  output logic [$clog2(NUM_REQS+2)-1:0]        level_o,
  output logic                                 overflow_o,
  input  logic                                 in_valid_i,
  input  logic [31:0]                          in_addr_i,
  input  logic [31:0]                          in_rdata_i,
  input  logic                                 in_err_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [31:0]                          out_addr_o,
  output logic [31:0]                          out_rdata_o,
  output logic                                 out_err_o,
  output logic                                 out_err_plus2_o,
  output logic                                 out_is_compressed_o
);

  localparam int unsigned DEPTH = NUM_REQS + 1;
  localparam int unsigned LW    = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] err_q, err_d;
  logic [31:0]      rdata_q [DEPTH];
  logic [31:0]      rdata_d [DEPTH];
  logic [31:0]      addr_q, addr_d;
  logic             overflow_q, overflow_d;

  logic [31:0] w_rdata, nx_rdata;
  logic        w_err, nx_err, w_avail, nx_avail;
  logic        unaligned, al_comp, un_comp;
  logic        accept, pop, push_en, push_drop, placed;

  // Head word falls back to the bus response; the second word exists only behind a stored head.
  assign w_rdata  = valid_q[0] ? rdata_q[0] : in_rdata_i;
  assign w_err    = valid_q[0] ? err_q[0]   : in_err_i;
  assign w_avail  = valid_q[0] | in_valid_i;
  assign nx_rdata = valid_q[1] ? rdata_q[1] : in_rdata_i;
  assign nx_err   = valid_q[1] ? err_q[1]   : in_err_i;
  assign nx_avail = valid_q[1] | (valid_q[0] & in_valid_i);

  assign unaligned = RV32C & addr_q[1];
  assign al_comp   = RV32C & (w_rdata[1:0] != 2'b11) & ~w_err;
  assign un_comp   = RV32C & (w_rdata[17:16] != 2'b11) & ~w_err;

  always_comb begin
    out_rdata_o         = w_rdata;
    out_valid_o         = w_avail;
    out_err_o           = w_err;
    out_err_plus2_o     = 1'b0;
    out_is_compressed_o = al_comp;
    if (unaligned) begin
      out_rdata_o         = {nx_rdata[15:0], w_rdata[31:16]};
      out_is_compressed_o = un_comp;
      if (un_comp) begin
        out_valid_o = w_avail;
        out_err_o   = w_err;
      end else begin
        out_valid_o     = w_avail & nx_avail;
        out_err_o       = w_err | nx_err;
        out_err_plus2_o = nx_err & ~w_err;
      end
    end
  end

  assign accept = out_valid_o & out_ready_i;
  // A compressed aligned instr leaves its upper half in the head word.
  assign pop    = accept & (unaligned | ~out_is_compressed_o);

  always_comb begin
    addr_d = addr_q;
    if (clear_i) begin
      addr_d = {in_addr_i[31:2], RV32C & in_addr_i[1], 1'b0};
    end else if (accept) begin
      addr_d = addr_q + (out_is_compressed_o ? 32'd2 : 32'd4);
    end
  end

  always_comb begin
    valid_d    = valid_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    overflow_d = overflow_q;
    placed     = 1'b0;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        valid_d[i] = valid_q[i+1];
        err_d[i]   = err_q[i+1];
        rdata_d[i] = rdata_q[i+1];
      end
      valid_d[DEPTH-1] = 1'b0;
    end
    // A bypassed word that was consumed outright is never stored.
    push_en   = in_valid_i & ~(pop & ~valid_q[0]);
    push_drop = push_en & valid_d[DEPTH-1];
    if (push_drop) begin
      overflow_d = 1'b1;
    end else if (push_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!placed && !valid_d[i]) begin
          valid_d[i] = 1'b1;
          err_d[i]   = in_err_i;
          rdata_d[i] = in_rdata_i;
          placed     = 1'b1;
        end
      end
    end
    if (clear_i) begin
      valid_d    = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= '0;
      err_q      <= '0;
      addr_q     <= {RESET_ADDR[31:2], RV32C & RESET_ADDR[1], 1'b0};
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) rdata_q[i] <= '0;
    end else begin
      valid_q    <= valid_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < DEPTH; i++) rdata_q[i] <= rdata_d[i];
    end
  end

  always_comb begin
    level_o = '0;
    for (int i = 0; i < DEPTH; i++) level_o = level_o + LW'(valid_q[i]);
  end

  assign busy_o     = valid_q[DEPTH-1:1];
  assign out_addr_o = addr_q;
  assign overflow_o = overflow_q;

`ifndef SYNTHESIS
  // The prefetcher is expected to throttle on busy_o; a drop here means it did not.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(in_valid_i && !clear_i && valid_q[DEPTH-1] && !pop))
        else $warning("fetch fifo: response dropped while full");
    end
  end
`endif

endmodule

// File: tb/tb_vcve2_fetch_fifo_gen.sv
// Scoreboard bench for vcve2_fetch_fifo_gen: expected instructions are queued as words are
// driven and compared whenever the IF side accepts one.
module tb_vcve2_fetch_fifo_gen;

  logic        clk_i = 1'b0;
  logic        rst_i, clear_i, in_valid_i, in_err_i, out_ready_i;
  logic [31:0] in_addr_i, in_rdata_i;
  logic [1:0]  busy_o;
  logic [1:0]  level_o;
  logic        overflow_o, out_valid_o, out_err_o, out_err_plus2_o, out_is_compressed_o;
  logic [31:0] out_addr_o, out_rdata_o;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
    logic        plus2;
    logic        comp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk_i = ~clk_i;

  vcve2_fetch_fifo_gen #(.NUM_REQS(2), .RV32C(1'b1), .RESET_ADDR(32'h80)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .busy_o(busy_o), .level_o(level_o),
    .overflow_o(overflow_o), .in_valid_i(in_valid_i), .in_addr_i(in_addr_i),
    .in_rdata_i(in_rdata_i), .in_err_i(in_err_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_addr_o(out_addr_o), .out_rdata_o(out_rdata_o),
    .out_err_o(out_err_o), .out_err_plus2_o(out_err_plus2_o),
    .out_is_compressed_o(out_is_compressed_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_instr(input logic [31:0] a, input logic [31:0] d, input logic e,
                              input logic p2, input logic c);
    exp_t x;
    x.addr = a; x.rdata = d; x.err = e; x.plus2 = p2; x.comp = c;
    sb.push_back(x);
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk_i);
    if (out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_accept", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("out_addr", out_addr_o, e.addr);
        if (e.comp) chk("out_rdata16", {16'h0, out_rdata_o[15:0]}, {16'h0, e.rdata[15:0]});
        else        chk("out_rdata", out_rdata_o, e.rdata);
        chk("out_err", {31'h0, out_err_o}, {31'h0, e.err});
        chk("out_err_plus2", {31'h0, out_err_plus2_o}, {31'h0, e.plus2});
        chk("out_is_compressed", {31'h0, out_is_compressed_o}, {31'h0, e.comp});
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    in_valid_i = 1'b0; clear_i = 1'b0; in_err_i = 1'b0; in_rdata_i = '0;
  endtask

  task automatic push(input logic [31:0] d, input logic e);
    in_valid_i = 1'b1; in_rdata_i = d; in_err_i = e;
  endtask

  task automatic do_clear(input logic [31:0] a);
    idle();
    clear_i = 1'b1; in_addr_i = a;
    step();
    idle();
  endtask

  initial begin
    rst_i = 1'b1; out_ready_i = 1'b0; in_addr_i = '0;
    idle();
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("rst_addr", out_addr_o, 32'h80);
    chk("rst_level", {30'h0, level_o}, 32'd0);
    chk("rst_valid", {31'h0, out_valid_o}, 32'd0);
    chk("rst_busy", {30'h0, busy_o}, 32'd0);
    chk("rst_overflow", {31'h0, overflow_o}, 32'd0);

    // bypass: word delivered the same cycle it arrives
    do_clear(32'h100);
    out_ready_i = 1'b1;
    push(32'h00B50513, 1'b0);
    expect_instr(32'h100, 32'h00B50513, 1'b0, 1'b0, 1'b0);
    #1;
    chk("byp_valid", {31'h0, out_valid_o}, 32'd1);
    step();
    idle(); #1;
    chk("byp_next_addr", out_addr_o, 32'h104);
    chk("byp_level", {30'h0, level_o}, 32'd0);
    chk("byp_idle_valid", {31'h0, out_valid_o}, 32'd0);

    // compressed pair in one word
    do_clear(32'h200);
    push(32'h45014581, 1'b0);
    expect_instr(32'h200, 32'h45014581, 1'b0, 1'b0, 1'b1);
    expect_instr(32'h202, 32'h00004501, 1'b0, 1'b0, 1'b1);
    step();
    idle();
    chk("cpair_level_mid", {30'h0, level_o}, 32'd1);
    step();
    chk("cpair_level_end", {30'h0, level_o}, 32'd0);
    chk("cpair_addr", out_addr_o, 32'h204);

    // unaligned 32-bit straddling two words
    do_clear(32'h102);
    push(32'h05134581, 1'b0);
    #1;
    chk("unal_wait", {31'h0, out_valid_o}, 32'd0);
    step();
    chk("unal_level_1", {30'h0, level_o}, 32'd1);
    push(32'h000000B5, 1'b0);
    expect_instr(32'h102, 32'h00B50513, 1'b0, 1'b0, 1'b0);
    expect_instr(32'h106, 32'h00000000, 1'b0, 1'b0, 1'b1);
    step();
    idle();
    step();
    chk("unal_level_end", {30'h0, level_o}, 32'd0);
    chk("unal_addr", out_addr_o, 32'h108);

    // error on second halfword
    do_clear(32'h102);
    push(32'h05134581, 1'b0);
    step();
    push(32'h000000B5, 1'b1);
    expect_instr(32'h102, 32'h00B50513, 1'b1, 1'b1, 1'b0);
    step();
    idle(); #1;
    chk("uerr_tail_valid", {31'h0, out_valid_o}, 32'd0);
    chk("uerr_level", {30'h0, level_o}, 32'd1);

    // fill past capacity with the IF stage stalled
    do_clear(32'h300);
    out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(32'h00000013 | (i << 7), 1'b0);
      if (i < 3) expect_instr(32'h300 + 4 * i, 32'h00000013 | (i << 7), 1'b0, 1'b0, 1'b0);
      step();
    end
    idle(); #1;
    chk("fill_level", {30'h0, level_o}, 32'd3);
    chk("fill_overflow", {31'h0, overflow_o}, 32'd1);
    chk("fill_busy", {30'h0, busy_o}, 32'd3);
    chk("fill_hold_valid", {31'h0, out_valid_o}, 32'd1);
    chk("fill_hold_addr", out_addr_o, 32'h300);
    chk("fill_hold_rdata", out_rdata_o, 32'h00000013);
    out_ready_i = 1'b1;
    repeat (3) step();
    chk("drain_level", {30'h0, level_o}, 32'd0);
    chk("drain_overflow_sticky", {31'h0, overflow_o}, 32'd1);
    chk("drain_addr", out_addr_o, 32'h30C);
    do_clear(32'h0);
    chk("clr_level", {30'h0, level_o}, 32'd0);
    chk("clr_overflow", {31'h0, overflow_o}, 32'd0);

    // PC wraps modulo 2^32
    do_clear(32'hFFFFFFFE);
    push(32'h45010000, 1'b0);
    expect_instr(32'hFFFFFFFE, 32'h00004501, 1'b0, 1'b0, 1'b1);
    step();
    idle(); #1;
    chk("wrap_addr", out_addr_o, 32'h0);
    chk("wrap_level", {30'h0, level_o}, 32'd0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
